// File: rtl/slotmaker_cfg_master.sv
// rtl/slotmaker_cfg_master.sv - slot-table configuration master: default load, host read/write, shadow map
module slotmaker_cfg_master #(
    parameter logic [63:0] DEFAULT_CARDS = 64'h05_00_00_02_00_00_03_00
) (
    input  logic        clk_logic,
    input  logic        system_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_slot,
    input  logic [7:0]  req_card,
    input  logic        lock_i,
    output logic        rsp_valid,
    output logic [7:0]  rsp_card,
    output logic        rsp_err,
    output logic [2:0]  cfg_slot,
    output logic [7:0]  cfg_card_i,
    output logic        cfg_wr,
    input  logic [7:0]  cfg_card_o,
    output logic [63:0] slot_map,
    output logic        map_changed,
    output logic        busy
);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_cnt;

    logic        r_write;
    logic [2:0]  r_slot;
    logic [7:0]  r_card;
    logic        r_lock;

    logic        r_req_ready, w_req_ready;
    logic        r_rsp_valid, w_rsp_valid;
    logic [7:0]  r_rsp_card,  w_rsp_card;
    logic        r_rsp_err,   w_rsp_err;
    logic [2:0]  r_cfg_slot,  w_cfg_slot;
    logic [7:0]  r_cfg_card,  w_cfg_card;
    logic        r_cfg_wr,    w_cfg_wr;
    logic [63:0] r_slot_map,  w_slot_map;
    logic        r_map_chg,   w_map_chg;
    logic        r_busy,      w_busy;

    logic        w_accept;
    logic        w_write_ok;
    logic [7:0]  w_old_card;
    logic [7:0]  w_new_card;

    assign w_accept   = req_valid && r_req_ready && (r_state == S_IDLE);
    assign w_write_ok = r_write && !r_lock;
    assign w_old_card = r_slot_map[{r_slot, 3'b000} +: 8];
    // A locked write degrades to a read, so it resyncs the shadow like any read.
    assign w_new_card = w_write_ok ? r_card : cfg_card_o;

    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            r_state <= S_INIT;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_INIT) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:  if (r_cnt == 3'd7) w_next_state = S_IDLE;
            S_IDLE:  if (w_accept)      w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_INIT;
        endcase
    end

    always_comb begin
        w_req_ready = r_req_ready;
        w_rsp_valid = r_rsp_valid;
        w_rsp_card  = r_rsp_card;
        w_rsp_err   = r_rsp_err;
        w_cfg_slot  = r_cfg_slot;
        w_cfg_card  = r_cfg_card;
        w_cfg_wr    = r_cfg_wr;
        w_slot_map  = r_slot_map;
        w_map_chg   = r_map_chg;
        w_busy      = r_busy;
        case (r_state)
            S_INIT: begin
                w_cfg_wr    = 1'b1;
                w_cfg_slot  = r_cnt;
                w_cfg_card  = DEFAULT_CARDS[{r_cnt, 3'b000} +: 8];
                w_req_ready = 1'b0;
                w_busy      = 1'b1;
            end
            S_IDLE: begin
                w_cfg_wr    = 1'b0;
                w_req_ready = 1'b1;
                w_busy      = 1'b0;
                w_rsp_valid = 1'b0;
                w_rsp_err   = 1'b0;
                w_map_chg   = 1'b0;
                if (w_accept) begin
                    w_req_ready = 1'b0;
                    w_busy      = 1'b1;
                    w_cfg_slot  = req_slot;
                    w_cfg_wr    = req_write && !lock_i;
                    if (req_write && !lock_i) begin
                        w_cfg_card = req_card;
                    end
                end
            end
            S_ISSUE: begin
                w_cfg_wr = 1'b0;
            end
            S_WAIT: begin
                w_rsp_valid = 1'b1;
                w_rsp_card  = cfg_card_o;
                w_rsp_err   = r_write && r_lock;
                w_slot_map[{r_slot, 3'b000} +: 8] = w_new_card;
                w_map_chg   = (w_new_card != w_old_card);
            end
            S_RESP: begin
                w_rsp_valid = 1'b0;
                w_rsp_err   = 1'b0;
                w_map_chg   = 1'b0;
                w_req_ready = 1'b1;
                w_busy      = 1'b0;
            end
            default: begin
                w_cfg_wr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            r_write <= 1'b0;
            r_slot  <= 3'd0;
            r_card  <= 8'd0;
            r_lock  <= 1'b0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_slot  <= req_slot;
            r_card  <= req_card;
            r_lock  <= lock_i;
        end
    end

    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_card  <= 8'd0;
            r_rsp_err   <= 1'b0;
            r_cfg_slot  <= 3'd0;
            r_cfg_card  <= 8'd0;
            r_cfg_wr    <= 1'b0;
            r_slot_map  <= DEFAULT_CARDS;
            r_map_chg   <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_req_ready <= w_req_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_card  <= w_rsp_card;
            r_rsp_err   <= w_rsp_err;
            r_cfg_slot  <= w_cfg_slot;
            r_cfg_card  <= w_cfg_card;
            r_cfg_wr    <= w_cfg_wr;
            r_slot_map  <= w_slot_map;
            r_map_chg   <= w_map_chg;
            r_busy      <= w_busy;
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_card    = r_rsp_card;
    assign rsp_err     = r_rsp_err;
    assign cfg_slot    = r_cfg_slot;
    assign cfg_card_i  = r_cfg_card;
    assign cfg_wr      = r_cfg_wr;
    assign slot_map    = r_slot_map;
    assign map_changed = r_map_chg;
    assign busy        = r_busy;

endmodule

// File: tb/tb_slotmaker_cfg_master.sv
// tb/tb_slotmaker_cfg_master.sv - scoreboard bench for slotmaker_cfg_master with slot-table model
module tb_slotmaker_cfg_master;

    localparam logic [63:0] DEF = 64'h05_00_00_02_00_00_03_00;

    logic        clk_logic = 1'b0;
    logic        system_reset;
    logic        req_valid, req_ready, req_write, lock_i;
    logic [2:0]  req_slot;
    logic [7:0]  req_card;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_card;
    logic [2:0]  cfg_slot;
    logic [7:0]  cfg_card_i, cfg_card_o;
    logic        cfg_wr;
    logic [63:0] slot_map;
    logic        map_changed, busy;

    always #5 clk_logic = ~clk_logic;

    slotmaker_cfg_master #(.DEFAULT_CARDS(DEF)) dut (
        .clk_logic(clk_logic), .system_reset(system_reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_slot(req_slot), .req_card(req_card), .lock_i(lock_i),
        .rsp_valid(rsp_valid), .rsp_card(rsp_card), .rsp_err(rsp_err),
        .cfg_slot(cfg_slot), .cfg_card_i(cfg_card_i), .cfg_wr(cfg_wr),
        .cfg_card_o(cfg_card_o), .slot_map(slot_map),
        .map_changed(map_changed), .busy(busy)
    );

    // Slot table environment: registered read, write data echoed, backdoor corruption port.
    logic [7:0] tbl [8];
    logic       corrupt_en = 1'b0;
    logic [2:0] corrupt_slot = 3'd0;
    logic [7:0] corrupt_val = 8'd0;
    always @(posedge clk_logic) begin
        if (cfg_wr) begin
            tbl[cfg_slot] <= cfg_card_i;
            cfg_card_o    <= cfg_card_i;
        end else begin
            cfg_card_o <= tbl[cfg_slot];
            if (corrupt_en) tbl[corrupt_slot] <= corrupt_val;
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk_logic) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: what the slot table holds and what the shadow should hold.
    logic [7:0] ref_tbl [8];
    logic [7:0] ref_map [8];

    function automatic logic [63:0] pack_map();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_map[i];
        return r;
    endfunction

    typedef struct {
        int          cyc;
        logic [7:0]  card;
        logic        err;
        logic [63:0] map;
        logic        chg;
    } exp_t;
    exp_t q[$];

    logic       mon_en = 1'b0;
    int         exp_iss_cyc = -1;
    logic       exp_wr = 1'b0;
    logic [2:0] exp_slot = 3'd0;
    logic [7:0] exp_card = 8'd0;

    always @(negedge clk_logic) begin
        if (rsp_valid) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_cycle", cyc, e.cyc);
                chk("rsp_card", rsp_card, e.card);
                chk("rsp_err", rsp_err, e.err);
                chk("slot_map", slot_map, e.map);
                chk("map_changed", map_changed, e.chg);
            end
        end else if (mon_en) begin
            chk("quiet_err", rsp_err, 1'b0);
            chk("quiet_map_changed", map_changed, 1'b0);
        end
        if (mon_en) begin
            chk("cfg_wr", cfg_wr, (cyc == exp_iss_cyc) && exp_wr);
            chk("busy", busy, !req_ready);
            if (cyc == exp_iss_cyc) begin
                chk("issue_slot", cfg_slot, exp_slot);
                if (exp_wr) chk("issue_card", cfg_card_i, exp_card);
            end
        end
    end

    task automatic do_reset();
        system_reset = 1'b1;
        req_valid = 1'b0;
        mon_en = 1'b0;
        q.delete();
        exp_iss_cyc = -1;
        @(negedge clk_logic);
        @(negedge clk_logic);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_card", rsp_card, 8'd0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_cfg_slot", cfg_slot, 3'd0);
        chk("rst_cfg_card_i", cfg_card_i, 8'd0);
        chk("rst_cfg_wr", cfg_wr, 1'b0);
        chk("rst_slot_map", slot_map, DEF);
        chk("rst_map_changed", map_changed, 1'b0);
        chk("rst_busy", busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            ref_tbl[i] = DEF[8*i +: 8];
            ref_map[i] = DEF[8*i +: 8];
        end
        system_reset = 1'b0;
    endtask

    // Returns at the negedge showing slot abort_at when abort_at < 8.
    task automatic init_check(input int abort_at);
        int n;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_logic);
            chk("init_wr", cfg_wr, 1'b1);
            chk("init_slot", cfg_slot, i[2:0]);
            chk("init_card", cfg_card_i, DEF[8*i +: 8]);
            chk("init_ready", req_ready, 1'b0);
            chk("init_map_changed", map_changed, 1'b0);
            if (i == abort_at) return;
        end
        @(negedge clk_logic);
        chk("init_end_wr", cfg_wr, 1'b0);
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk_logic);
            n++;
        end
        chk("init_ready_up", req_ready, 1'b1);
        chk("init_map", slot_map, DEF);
        mon_en = 1'b1;
    endtask

    task automatic send(input logic w, input logic [2:0] s, input logic [7:0] c,
                        input logic l, output int acc);
        int n;
        logic ok;
        logic [7:0] nv;
        req_valid = 1'b1;
        req_write = w;
        req_slot  = s;
        req_card  = c;
        lock_i    = l;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk_logic);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        ok = w && !l;
        exp_iss_cyc = cyc + 1;
        exp_wr   = ok;
        exp_slot = s;
        exp_card = c;
        if (ok) ref_tbl[s] = c;
        nv = ref_tbl[s];
        q.push_back('{cyc: cyc + 3, card: nv, err: w && l, map: 64'd0, chg: (ref_map[s] != nv)});
        ref_map[s] = nv;
        q[q.size()-1].map = pack_map();
        @(negedge clk_logic);
        lock_i = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = 1'b0;
        while ((q.size() > 0 || !req_ready) && n < 20) begin
            @(negedge clk_logic);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic corrupt(input logic [2:0] s, input logic [7:0] v);
        corrupt_en = 1'b1;
        corrupt_slot = s;
        corrupt_val = v;
        @(negedge clk_logic);
        corrupt_en = 1'b0;
        ref_tbl[s] = v;
    endtask

    initial begin
        int a1, a2;
        system_reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_slot = 3'd0;
        req_card = 8'd0;
        lock_i = 1'b0;
        @(negedge clk_logic);
        do_reset();
        init_check(8);

        send(1'b0, 3'd1, 8'h00, 1'b0, a1); drain();
        send(1'b1, 3'd6, 8'h07, 1'b0, a1); drain();
        send(1'b0, 3'd6, 8'h00, 1'b0, a1); drain();
        send(1'b1, 3'd4, 8'h09, 1'b1, a1); drain();
        send(1'b1, 3'd2, 8'h11, 1'b0, a1);
        send(1'b1, 3'd3, 8'h22, 1'b0, a2);
        chk("b2b_spacing", a2 - a1, 4);
        drain();
        corrupt(3'd5, 8'h5A);
        send(1'b0, 3'd5, 8'h00, 1'b0, a1); drain();

        for (int i = 0; i < 250; i++) begin
            send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 255)),
                 1'($urandom_range(0, 3) == 0), a1);
            if ($urandom_range(0, 2) != 0) begin
                req_valid = 1'b0;
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) @(negedge clk_logic);
            end
            if ($urandom_range(0, 15) == 0) begin
                drain();
                corrupt(3'($urandom_range(0, 7)), 8'($urandom));
            end
        end
        drain();

        do_reset();
        init_check(4);
        do_reset();
        init_check(8);

        send(1'b1, 3'd0, 8'hC3, 1'b0, a1);
        req_valid = 1'b0;
        @(negedge clk_logic);
        do_reset();
        init_check(8);
        send(1'b0, 3'd0, 8'h00, 1'b0, a1); drain();
        send(1'b0, 3'd6, 8'h00, 1'b0, a1); drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
